bram_fifo_ctrl: RTL and testbench

BRAM_FIFO_CTRL -- requirements
Module: bram_fifo_ctrl

---
 rtl/bram_fifo_pkg.sv | 11 +
 rtl/bram_fifo_outbuf.sv | 72 +++++++
 rtl/bram_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_bram_fifo_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_fifo_pkg.sv
// Shared constants for the BRAM-backed show-ahead FIFO controller.
// Geometry of the DPB2-style RAM ports and output-buffer depth.
package bram_fifo_pkg;
    localparam int RAM_AD_W     = 14;
    localparam int RAM_DI_W     = 18;
    localparam int OUTBUF_DEPTH = 2;
    localparam int DEF_ADDR_W   = 11;
    localparam int DEF_DATA_W   = 8;

    typedef logic [$clog2(OUTBUF_DEPTH+1)-1:0] occ_t;
endpackage

// File: rtl/bram_fifo_outbuf.sv
// Two-entry show-ahead skid buffer that absorbs RAM read data.
// Head register drives the output; tail catches data while the head is stalled.
module bram_fifo_outbuf
    import bram_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_cap,
    input  logic [DATA_W-1:0] i_cap_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output occ_t              o_occ
);
    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    occ_t              r_occ;
    logic              w_pop;

    assign w_pop   = (r_occ != '0) & i_ready;
    assign o_valid = (r_occ != '0);
    assign o_data  = r_head;
    assign o_occ   = r_occ;

    // The controller never issues a read that could land on a full buffer
    // without a matching pop, so capture-without-pop at occupancy 2 cannot occur.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else if (i_flush) begin
            r_occ  <= '0;
            r_head <= '0;
            r_tail <= '0;
        end else begin
            case (r_occ)
                occ_t'(0): begin
                    if (i_cap) begin
                        r_head <= i_cap_data;
                        r_occ  <= occ_t'(1);
                    end
                end
                occ_t'(1): begin
                    if (i_cap) begin
                        if (w_pop) begin
                            r_head <= i_cap_data;
                        end else begin
                            r_tail <= i_cap_data;
                            r_occ  <= occ_t'(2);
                        end
                    end else if (w_pop) begin
                        r_occ <= occ_t'(0);
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_cap) begin
                            r_tail <= i_cap_data;
                        end else begin
                            r_occ <= occ_t'(1);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller over a dual-port BRAM: port A writes, port B reads into a
// 2-entry show-ahead buffer. Define BRAM_FIFO_COUNT_EN to build the COUNT output.
module bram_fifo_ctrl
    import bram_fifo_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic                FLUSH,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [DATA_W-1:0]   IN_DATA,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [DATA_W-1:0]   OUT_DATA,
    output logic                RAM_CEA,
    output logic                RAM_WREA,
    output logic [RAM_AD_W-1:0] RAM_ADA,
    output logic [RAM_DI_W-1:0] RAM_DIA,
    output logic                RAM_CEB,
    output logic                RAM_OCEB,
    output logic [RAM_AD_W-1:0] RAM_ADB,
    input  logic [DATA_W-1:0]   RAM_DOB,
    output logic [ADDR_W+1:0]   COUNT
);
    localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_ram_cnt;
    logic              r_infl;
    logic              r_alive;
    logic              w_push;
    logic              w_pop;
    logic              w_issue;
    logic              w_full;
    logic              w_empty;
    occ_t              w_occ;
    occ_t              w_pend;

    assign w_full   = (r_ram_cnt == FULL_CNT);
    assign w_empty  = (r_ram_cnt == '0);
    // r_alive holds IN_READY low until the first clock after reset release.
    assign IN_READY = r_alive & ~w_full & ~FLUSH;
    assign w_push   = IN_VALID & IN_READY;
    assign w_pop    = OUT_VALID & OUT_READY;
    assign w_pend   = w_occ + occ_t'(r_infl);
    // A same-cycle pop frees a buffer slot, which keeps reads back-to-back.
    assign w_issue  = r_alive & ~FLUSH & ~w_empty &
                      ((w_pend < occ_t'(OUTBUF_DEPTH)) | w_pop);

    always_comb begin
        RAM_ADA                = '0;
        RAM_ADA[ADDR_W-1:0]    = r_wr_ptr;
        RAM_DIA                = '0;
        RAM_DIA[DATA_W-1:0]    = IN_DATA;
        RAM_ADB                = '0;
        RAM_ADB[ADDR_W-1:0]    = r_rd_ptr;
        RAM_CEA                = w_push;
        RAM_WREA               = w_push;
        RAM_CEB                = w_issue;
        RAM_OCEB               = w_issue;
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_ram_cnt <= '0;
            r_infl    <= 1'b0;
            r_alive   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (FLUSH) begin
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_ram_cnt <= '0;
                r_infl    <= 1'b0;
            end else begin
                if (w_push)  r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_issue) r_rd_ptr <= r_rd_ptr + 1'b1;
                r_infl <= w_issue;
                case ({w_push, w_issue})
                    2'b10:   r_ram_cnt <= r_ram_cnt + 1'b1;
                    2'b01:   r_ram_cnt <= r_ram_cnt - 1'b1;
                    default: r_ram_cnt <= r_ram_cnt;
                endcase
            end
        end
    end

    bram_fifo_outbuf #(.DATA_W(DATA_W)) u_outbuf (
        .i_clk      (CLK),
        .i_rst_n    (RESETN),
        .i_flush    (FLUSH),
        .i_cap      (r_infl),
        .i_cap_data (RAM_DOB),
        .i_ready    (OUT_READY),
        .o_valid    (OUT_VALID),
        .o_data     (OUT_DATA),
        .o_occ      (w_occ)
    );

`ifdef BRAM_FIFO_COUNT_EN
    // Tracks ram_cnt + in-flight + buffered as one push/pop accumulator.
    logic [ADDR_W+1:0] r_count;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_count <= '0;
        end else if (FLUSH) begin
            r_count <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign COUNT = r_count;
`else
    assign COUNT = '0;
`endif
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed bench for bram_fifo_ctrl with a DPB2-style 1-cycle-latency RAM model.
// COUNT expectations follow BRAM_FIFO_COUNT_EN (0 when the macro is undefined).
module tb_bram_fifo_ctrl;
    localparam int AW = 11;
    localparam int DW = 8;

    logic          CLK;
    logic          RESETN;
    logic          FLUSH;
    logic          IN_VALID;
    logic          IN_READY;
    logic [DW-1:0] IN_DATA;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [DW-1:0] OUT_DATA;
    logic          RAM_CEA;
    logic          RAM_WREA;
    logic [13:0]   RAM_ADA;
    logic [17:0]   RAM_DIA;
    logic          RAM_CEB;
    logic          RAM_OCEB;
    logic [13:0]   RAM_ADB;
    logic [DW-1:0] RAM_DOB;
    logic [AW+1:0] COUNT;

    int checks   = 0;
    int failures = 0;

    bram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .RESETN(RESETN), .FLUSH(FLUSH),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
        .RAM_CEA(RAM_CEA), .RAM_WREA(RAM_WREA), .RAM_ADA(RAM_ADA), .RAM_DIA(RAM_DIA),
        .RAM_CEB(RAM_CEB), .RAM_OCEB(RAM_OCEB), .RAM_ADB(RAM_ADB), .RAM_DOB(RAM_DOB),
        .COUNT(COUNT)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] r_dob;

    always @(posedge CLK) begin
        if (RAM_CEA && RAM_WREA) mem[RAM_ADA[AW-1:0]] <= RAM_DIA[DW-1:0];
        if (RAM_CEB && RAM_OCEB) r_dob <= mem[RAM_ADB[AW-1:0]];
    end
    assign RAM_DOB = r_dob;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int ec(input int n);
`ifdef BRAM_FIFO_COUNT_EN
        return n;
`else
        return 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    logic [DW-1:0] q[$];
    int rx;
    int cyc;
    int pushes;

    initial begin
        RESETN = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b0; IN_DATA = '0; OUT_READY = 1'b0;
        repeat (2) @(posedge CLK);
        #2;
        check("rst_in_ready", IN_READY, 0);
        check("rst_out_valid", OUT_VALID, 0);
        check("rst_out_data", OUT_DATA, 0);
        check("rst_count", COUNT, 0);
        check("rst_cea", RAM_CEA, 0);
        check("rst_ceb", RAM_CEB, 0);
        #3 RESETN = 1'b1;
        tick;
        check("rel_in_ready", IN_READY, 1);

        // latency: push at cycle 0, visible at cycle 3
        IN_VALID = 1'b1; IN_DATA = 8'h5A; OUT_READY = 1'b1;
        #1;
        check("s1_cea", RAM_CEA, 1);
        check("s1_wrea", RAM_WREA, 1);
        check("s1_ada", RAM_ADA, 0);
        check("s1_dia", RAM_DIA, 32'h5A);
        tick; IN_VALID = 1'b0;
        check("s1_c1_cnt", COUNT, ec(1));
        check("s1_c1_vld", OUT_VALID, 0);
        #1;
        check("s1_c1_ceb", RAM_CEB, 1);
        check("s1_c1_oceb", RAM_OCEB, 1);
        check("s1_c1_adb", RAM_ADB, 0);
        tick;
        check("s1_c2_cnt", COUNT, ec(1));
        check("s1_c2_vld", OUT_VALID, 0);
        check("s1_c2_ceb", RAM_CEB, 0);
        tick;
        check("s1_c3_vld", OUT_VALID, 1);
        check("s1_c3_data", OUT_DATA, 32'h5A);
        check("s1_c3_cnt", COUNT, ec(1));
        tick;
        check("s1_c4_vld", OUT_VALID, 0);
        check("s1_c4_cnt", COUNT, ec(0));

        // fill to capacity with the output stalled
        OUT_READY = 1'b0;
        for (int i = 0; i < 2050; i++) begin
            check("s2_rdy", IN_READY, 1);
            IN_VALID = 1'b1; IN_DATA = i[7:0];
            tick;
        end
        IN_VALID = 1'b0;
        #1;
        check("s2_full_rdy", IN_READY, 0);
        check("s2_full_cnt", COUNT, ec(2050));
        check("s2_head_vld", OUT_VALID, 1);
        check("s2_head_data", OUT_DATA, 0);
        OUT_READY = 1'b1; rx = 0; cyc = 0;
        while (rx < 2050 && cyc < 3000) begin
            if (OUT_VALID) begin
                check("s2_data", OUT_DATA, rx & 255);
                rx++;
            end
            tick;
            cyc++;
        end
        check("s2_rx", rx, 2050);
        check("s2_nobubble", cyc, 2050);
        check("s2_end_cnt", COUNT, ec(0));
        check("s2_end_vld", OUT_VALID, 0);
        check("s2_end_rdy", IN_READY, 1);

        // streaming with random back-pressure
        pushes = 0;
        for (int c = 0; c < 5000; c++) begin
            OUT_READY = 1'($urandom_range(0, 1));
            IN_VALID = 1'b1; IN_DATA = DW'($urandom);
            #1;
            if (IN_READY) begin
                q.push_back(IN_DATA);
                pushes++;
            end
            if (OUT_VALID && OUT_READY) begin
                check("s3_data", OUT_DATA, (q.size() > 0) ? q[0] : 32'hDEAD);
                if (q.size() > 0) void'(q.pop_front());
            end
            tick;
            check("s3_cnt", COUNT, ec(q.size()));
        end
        IN_VALID = 1'b0; OUT_READY = 1'b1; cyc = 0;
        while (q.size() > 0 && cyc < 3000) begin
            if (OUT_VALID) begin
                check("s3_drain", OUT_DATA, q[0]);
                void'(q.pop_front());
            end
            tick;
            cyc++;
        end
        check("s3_left", q.size(), 0);
        check("s3_wrap", (pushes > 4096) ? 1 : 0, 1);
        check("s3_end_cnt", COUNT, ec(0));
        check("s3_end_vld", OUT_VALID, 0);

        // flush beats a simultaneous push
        OUT_READY = 1'b0;
        for (int i = 0; i < 10; i++) begin
            IN_VALID = 1'b1; IN_DATA = 8'h40 + i[7:0];
            tick;
        end
        IN_VALID = 1'b0;
        repeat (4) tick;
        check("s4_cnt10", COUNT, ec(10));
        check("s4_head", OUT_DATA, 32'h40);
        FLUSH = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'hEE;
        #1;
        check("s4_fl_rdy", IN_READY, 0);
        check("s4_fl_cea", RAM_CEA, 0);
        check("s4_fl_ceb", RAM_CEB, 0);
        tick;
        FLUSH = 1'b0; IN_VALID = 1'b0;
        check("s4_cnt0", COUNT, ec(0));
        check("s4_vld0", OUT_VALID, 0);
        repeat (4) tick;
        check("s4_absent", OUT_VALID, 0);
        OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'h11;
        #1;
        check("s4_ada", RAM_ADA, 0);
        tick; IN_VALID = 1'b0;
        tick;
        tick;
        check("s4_c3_vld", OUT_VALID, 1);
        check("s4_c3_data", OUT_DATA, 32'h11);
        tick;
        check("s4_c4_vld", OUT_VALID, 0);

        // asynchronous reset with a read in flight
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_DATA = 8'hA1;
        tick;
        IN_DATA = 8'hA2;
        tick;
        IN_VALID = 1'b0;
        tick;
        check("s5_pre_vld", OUT_VALID, 1);
        check("s5_pre_data", OUT_DATA, 32'hA1);
        #3 RESETN = 1'b0;
        #1;
        check("s5_rst_vld", OUT_VALID, 0);
        check("s5_rst_data", OUT_DATA, 0);
        check("s5_rst_rdy", IN_READY, 0);
        check("s5_rst_cnt", COUNT, 0);
        check("s5_rst_ceb", RAM_CEB, 0);
        repeat (2) @(posedge CLK);
        #5 RESETN = 1'b1;
        tick;
        check("s5_rel_rdy", IN_READY, 1);
        OUT_READY = 1'b1; IN_VALID = 1'b1; IN_DATA = 8'hC3;
        tick; IN_VALID = 1'b0;
        check("s5_c1_vld", OUT_VALID, 0);
        tick;
        check("s5_c2_vld", OUT_VALID, 0);
        tick;
        check("s5_c3_vld", OUT_VALID, 1);
        check("s5_c3_data", OUT_DATA, 32'hC3);
        tick;
        check("s5_c4_vld", OUT_VALID, 0);
        check("s5_c4_cnt", COUNT, ec(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
